// File: rtl/apb3_master_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb3_master_arbiter_if : two requester handshakes plus the shared APB3 bus
// Rev 1.0
// ----------------------------------------------------------------------------
interface apb3_master_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic                  req0_write;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  req0_done;
  logic [DATA_WIDTH-1:0] req0_rdata;
  logic                  req0_err;

  logic                  req1_valid;
  logic                  req1_write;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  req1_done;
  logic [DATA_WIDTH-1:0] req1_rdata;
  logic                  req1_err;

  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERROR;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    output req0_done, req0_rdata, req0_err,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_done, req1_rdata, req1_err,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERROR
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    input  req0_done, req0_rdata, req0_err,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_done, req1_rdata, req1_err,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERROR
  );
endinterface
`default_nettype wire

// File: rtl/apb3_master_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb3_master_arbiter : round-robin two-port APB3 master with ACCESS timeout
// Rev 1.0
// ----------------------------------------------------------------------------
module apb3_master_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  resetn,
  apb3_master_arbiter_if.master bus_if
);
  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic                       grant_q, grant_d;
  logic                       last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0]      paddr_q, paddr_d;
  logic                       pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]      pwdata_q, pwdata_d;
  logic [CNT_W-1:0]           wait_cnt_q, wait_cnt_d;
  logic [1:0]                 done_q, done_d;
  logic [1:0]                 err_q, err_d;
  logic [1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [1:0] valid;
  logic [1:0] eligible;
  logic       winner;
  logic       access_end;

  // A port finishing this cycle may still show its old valid; mask it
  assign valid      = {bus_if.req1_valid, bus_if.req0_valid};
  assign eligible   = valid & ~done_q;
  assign winner     = (&eligible) ? ~last_grant_q : eligible[1];
  assign access_end = bus_if.PREADY || (wait_cnt_q == TO_LAST);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    wait_cnt_d   = wait_cnt_q;
    done_d       = '0;
    err_d        = '0;
    rdata_d      = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          state_d      = ST_SETUP;
          grant_d      = winner;
          last_grant_d = winner;
          paddr_d      = winner ? bus_if.req1_addr  : bus_if.req0_addr;
          pwrite_d     = winner ? bus_if.req1_write : bus_if.req0_write;
          pwdata_d     = winner ? bus_if.req1_wdata : bus_if.req0_wdata;
          wait_cnt_d   = '0;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (access_end) begin
          // A late PREADY on the final cycle still counts as a real response
          state_d         = ST_IDLE;
          wait_cnt_d      = '0;
          done_d[grant_q] = 1'b1;
          err_d[grant_q]  = bus_if.PREADY ? bus_if.PSLVERROR : 1'b1;
          if (!pwrite_q) begin
            rdata_d[grant_q] = bus_if.PREADY ? bus_if.PRDATA : '0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      wait_cnt_q   <= '0;
      done_q       <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      wait_cnt_q   <= wait_cnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus_if.PSEL       = (state_q != ST_IDLE);
  assign bus_if.PENABLE    = (state_q == ST_ACCESS);
  assign bus_if.PADDR      = paddr_q;
  assign bus_if.PWRITE     = pwrite_q;
  assign bus_if.PWDATA     = pwdata_q;
  assign bus_if.req0_done  = done_q[0];
  assign bus_if.req0_err   = err_q[0];
  assign bus_if.req0_rdata = rdata_q[0];
  assign bus_if.req1_done  = done_q[1];
  assign bus_if.req1_err   = err_q[1];
  assign bus_if.req1_rdata = rdata_q[1];
endmodule
`default_nettype wire

// File: tb/tb_apb3_master_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_apb3_master_arbiter : directed self-checking bench, TIMEOUT_CYCLES = 4
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_apb3_master_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   n_chk  = 0;
  int   n_bad  = 0;

  apb3_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  apb3_master_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk   (clk),
    .resetn(resetn),
    .bus_if(bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Each cycle starts 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit p, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p) begin
      bus_if.req1_valid = v; bus_if.req1_write = w;
      bus_if.req1_addr  = a; bus_if.req1_wdata = d;
    end else begin
      bus_if.req0_valid = v; bus_if.req0_write = w;
      bus_if.req0_addr  = a; bus_if.req0_wdata = d;
    end
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    bus_if.PREADY    = 1'b0;
    bus_if.PSLVERROR = 1'b0;
    bus_if.PRDATA    = '0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    bus_if.PREADY    = 1'b0;
    bus_if.PSLVERROR = 1'b0;
    bus_if.PRDATA    = '0;
    tick();
    tick();

    chk("rst_psel",    32'(bus_if.PSEL),       0);
    chk("rst_penable", 32'(bus_if.PENABLE),    0);
    chk("rst_pwrite",  32'(bus_if.PWRITE),     0);
    chk("rst_paddr",   32'(bus_if.PADDR),      0);
    chk("rst_pwdata",  bus_if.PWDATA,          0);
    chk("rst_done0",   32'(bus_if.req0_done),  0);
    chk("rst_done1",   32'(bus_if.req1_done),  0);
    chk("rst_rdata0",  bus_if.req0_rdata,      0);
    chk("rst_rdata1",  bus_if.req1_rdata,      0);
    resetn = 1'b1;

    // Single read, two wait states, valid held through the done cycle
    set_req(0, 1, 0, 16'h0008, '0);
    bus_if.PRDATA = 32'h0000_0A5A;
    chk("a_c0_psel", 32'(bus_if.PSEL), 0);
    tick();
    chk("a_c1_psel",    32'(bus_if.PSEL),    1);
    chk("a_c1_penable", 32'(bus_if.PENABLE), 0);
    chk("a_c1_paddr",   32'(bus_if.PADDR),   'h0008);
    chk("a_c1_pwrite",  32'(bus_if.PWRITE),  0);
    tick();
    chk("a_c2_penable", 32'(bus_if.PENABLE), 1);
    bus_if.req0_addr = 16'h00FF;
    tick();
    chk("a_c3_paddr_frozen", 32'(bus_if.PADDR),     'h0008);
    chk("a_c3_done0",        32'(bus_if.req0_done), 0);
    tick();
    bus_if.PREADY = 1'b1;
    tick();
    bus_if.PREADY = 1'b0;
    chk("a_c5_done0",  32'(bus_if.req0_done), 1);
    chk("a_c5_rdata0", bus_if.req0_rdata,     'h0000_0A5A);
    chk("a_c5_err0",   32'(bus_if.req0_err),  0);
    chk("a_c5_psel",   32'(bus_if.PSEL),      0);
    tick();
    chk("a_c6_no_regrant", 32'(bus_if.PSEL),      0);
    chk("a_c6_done0_low",  32'(bus_if.req0_done), 0);
    chk("a_c6_paddr_hold", 32'(bus_if.PADDR),     'h0008);
    set_req(0, 0, 0, '0, '0);
    tick();

    // Timeout: slave never ready
    set_req(0, 1, 0, 16'h0030, '0);
    repeat (5) tick();
    chk("b_c5_penable", 32'(bus_if.PENABLE), 1);
    tick();
    chk("b_c6_done0",  32'(bus_if.req0_done), 1);
    chk("b_c6_err0",   32'(bus_if.req0_err),  1);
    chk("b_c6_rdata0", bus_if.req0_rdata,     0);
    chk("b_c6_psel",   32'(bus_if.PSEL),      0);
    set_req(0, 0, 0, '0, '0);
    tick();
    chk("b_c7_done0", 32'(bus_if.req0_done), 0);

    // PREADY on the cycle the timeout would fire: normal completion
    set_req(1, 1, 0, 16'h0040, '0);
    tick();
    chk("c_c1_paddr", 32'(bus_if.PADDR), 'h0040);
    repeat (4) tick();
    bus_if.PREADY = 1'b1;
    bus_if.PRDATA = 32'h0000_BEEF;
    tick();
    bus_if.PREADY = 1'b0;
    chk("c_c6_done1",  32'(bus_if.req1_done), 1);
    chk("c_c6_err1",   32'(bus_if.req1_err),  0);
    chk("c_c6_rdata1", bus_if.req1_rdata,     'h0000_BEEF);
    chk("c_c6_done0",  32'(bus_if.req0_done), 0);
    set_req(1, 0, 0, '0, '0);
    tick();

    // Write with slave error; PREADY high outside ACCESS is ignored
    set_req(1, 1, 1, 16'h0044, 32'h77);
    bus_if.PREADY    = 1'b1;
    bus_if.PSLVERROR = 1'b1;
    tick();
    chk("d_c1_penable", 32'(bus_if.PENABLE), 0);
    chk("d_c1_pwrite",  32'(bus_if.PWRITE),  1);
    chk("d_c1_pwdata",  bus_if.PWDATA,       'h77);
    tick();
    chk("d_c2_penable", 32'(bus_if.PENABLE), 1);
    tick();
    chk("d_c3_done1",  32'(bus_if.req1_done), 1);
    chk("d_c3_err1",   32'(bus_if.req1_err),  1);
    chk("d_c3_rdata1", bus_if.req1_rdata,     'h0000_BEEF);
    bus_if.PREADY    = 1'b0;
    bus_if.PSLVERROR = 1'b0;
    set_req(1, 0, 0, '0, '0);

    // Fresh reset: tie goes to port 0, then alternation
    apply_reset();
    bus_if.PREADY = 1'b1;
    bus_if.PRDATA = 32'h1111_2222;
    set_req(0, 1, 1, 16'h0004, 32'h1);
    set_req(1, 1, 0, 16'h0000, '0);
    tick();
    chk("e_c1_paddr",  32'(bus_if.PADDR),  'h0004);
    chk("e_c1_pwrite", 32'(bus_if.PWRITE), 1);
    chk("e_c1_pwdata", bus_if.PWDATA,      1);
    tick();
    tick();
    chk("e_c3_done0",  32'(bus_if.req0_done), 1);
    chk("e_c3_err0",   32'(bus_if.req0_err),  0);
    chk("e_c3_rdata0", bus_if.req0_rdata,     0);
    chk("e_c3_done1",  32'(bus_if.req1_done), 0);
    chk("e_c3_psel",   32'(bus_if.PSEL),      0);
    set_req(0, 1, 1, 16'h000C, 32'h55);
    tick();
    chk("e_c4_psel",    32'(bus_if.PSEL),    1);
    chk("e_c4_penable", 32'(bus_if.PENABLE), 0);
    chk("e_c4_paddr",   32'(bus_if.PADDR),   'h0000);
    chk("e_c4_pwrite",  32'(bus_if.PWRITE),  0);
    tick();
    tick();
    chk("e_c6_done1",  32'(bus_if.req1_done), 1);
    chk("e_c6_rdata1", bus_if.req1_rdata,     'h1111_2222);
    tick();
    set_req(1, 0, 0, '0, '0);
    chk("e_c7_paddr",  32'(bus_if.PADDR),  'h000C);
    chk("e_c7_pwrite", 32'(bus_if.PWRITE), 1);
    chk("e_c7_pwdata", bus_if.PWDATA,      'h55);
    tick();
    tick();
    chk("e_c9_done0", 32'(bus_if.req0_done), 1);
    set_req(0, 0, 0, '0, '0);
    tick();
    chk("e_c10_psel", 32'(bus_if.PSEL), 0);
    set_req(0, 1, 0, 16'h0010, '0);
    set_req(1, 1, 0, 16'h0020, '0);
    tick();
    chk("e_c11_tie_port1", 32'(bus_if.PADDR), 'h0020);

    // Reset during ACCESS aborts silently, pending request restarts
    apply_reset();
    set_req(0, 1, 0, 16'h0050, '0);
    tick();
    tick();
    chk("f_c2_penable", 32'(bus_if.PENABLE), 1);
    resetn = 1'b0;
    #1;
    chk("f_async_psel",    32'(bus_if.PSEL),    0);
    chk("f_async_penable", 32'(bus_if.PENABLE), 0);
    tick();
    chk("f_c3_done0", 32'(bus_if.req0_done), 0);
    resetn = 1'b1;
    tick();
    chk("f_c4_psel",    32'(bus_if.PSEL),      1);
    chk("f_c4_penable", 32'(bus_if.PENABLE),   0);
    chk("f_c4_paddr",   32'(bus_if.PADDR),     'h0050);
    chk("f_c4_done0",   32'(bus_if.req0_done), 0);
    bus_if.PREADY = 1'b1;
    bus_if.PRDATA = 32'h0000_0099;
    tick();
    tick();
    chk("f_c6_done0",  32'(bus_if.req0_done), 1);
    chk("f_c6_rdata0", bus_if.req0_rdata,     'h0000_0099);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/apb3_master_arbiter.md
# apb3_master_arbiter

Two-port APB3 master that lets two on-chip requesters share one APB3 bus to the video-pipeline register slave. Requester 0 is the host/CPU bridge and requester 1 is the frame-rate config engine that updates scaler size and algorithm registers. The block arbitrates round-robin and runs the APB3 SETUP/ACCESS protocol with a wait-state timeout. It returns read data and error status to the granted requester.

## Interface
- ADDR_WIDTH, 16, APB address width
- DATA_WIDTH, 32, APB data width
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before forced termination (≥2)
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- reqN_valid (N=0,1)  in  1  request pending; held with fields stable until reqN_done
- reqN_write  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_WIDTH  byte address
- reqN_wdata  in  DATA_WIDTH  write data
- reqN_done  out  1  one-cycle completion pulse
- reqN_rdata  out  DATA_WIDTH  read data, valid with reqN_done, held until next done on that port
- reqN_err  out  1  valid with reqN_done: PSLVERROR or timeout
- PADDR  out  ADDR_WIDTH
- PSEL, PENABLE, PWRITE  out  1
- PWDATA  out  DATA_WIDTH
- PRDATA  in  DATA_WIDTH
- PREADY, PSLVERROR  in  1

## Operation
- FSM states:
  - IDLE: PSEL=0, PENABLE=0.
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
- IDLE → SETUP when any eligible request is valid.
  - In the same clock edge: latch the winner's write, addr and wdata into PWRITE, PADDR and PWDATA; record grant id.
- SETUP → ACCESS unconditionally after one cycle.
- ACCESS, on PREADY=1:
  - Capture PRDATA (reads only; writes leave reqN_rdata unchanged) and PSLVERROR.
  - Next cycle: pulse done/err for the granted port; state returns to IDLE.
- ACCESS timeout: wait counter increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES−1 with PREADY still 0, terminate as if PREADY arrived.
  - err=1; rdata=0 for reads.
- Eligibility: a port whose done is high in the current cycle is masked in IDLE. This prevents a stale valid from re-granting the same transaction.
- Arbitration, both eligible: grant the port not granted last.
  - last_grant resets to 1, so port 0 wins the first tie.
  - last_grant updates only on IDLE→SETUP.
- Single eligible requester: it wins regardless of last_grant.
- PADDR, PWRITE and PWDATA hold their values in IDLE; they are not zeroed.
- Requester fields are sampled only at grant. Changes after grant do not affect the bus.

## Timing
- Reset values:
  - State IDLE; PSEL, PENABLE, PWRITE = 0.
  - PADDR, PWDATA = 0.
  - reqN_done, reqN_err = 0; reqN_rdata = 0.
  - Wait counter 0; last_grant = 1.
- Reset asserted mid-transfer: bus drops to reset values asynchronously. No done pulse is issued. The requester must re-issue.
- Cycle numbering, with valid seen in IDLE at cycle 0:
  - Cycle 1: SETUP.
  - Cycle 2: first ACCESS cycle.
  - Cycle k: PREADY sampled high (k ≥ 2).
  - Cycle k+1: done=1 and IDLE.
  - The next grant can start at cycle k+1 (other port) or k+2 (same port re-requesting).
- Minimum valid→done latency is 3 cycles with a zero-wait slave.
- PREADY and PSLVERROR are ignored outside ACCESS.
- Timeout fires on the TIMEOUT_CYCLES-th ACCESS cycle. done follows one cycle later.
- PREADY arriving on the same cycle the timeout would fire is a normal completion: err=PSLVERROR, data captured.

## Test plan
- Single read, port 0, addr 0x0008, slave inserts 2 wait cycles, PRDATA=0x0000_0A5A → SETUP at cycle 1, PREADY at cycle 4, req0_done at cycle 5 with rdata=0x0000_0A5A, err=0.
- Both ports valid at cycle 0 (port 0 write 0x0004←0x1, port 1 read 0x0000), zero-wait slave → port 0 done at cycle 3, port 1 SETUP at cycle 4 and done at cycle 6; both held valid again → port 0 wins next (alternation).
- Port 0 keeps valid high for one cycle after done → no second transfer is launched for it.
- Slave never asserts PREADY, TIMEOUT_CYCLES=4 → ACCESS cycles 2–5, done at cycle 6 with err=1 and rdata=0; PSEL=0 at cycle 6.
- PSLVERROR=1 with PREADY on a write → done with err=1; reqN_rdata unchanged.
- resetn pulsed low during ACCESS → PSEL and PENABLE drop immediately, no done; after release, the pending port 0 request restarts from SETUP.
